pc_return_stack: RTL and testbench

- Hardware call/return stack that sits directly beside the program counter stage.
- The decoder's CALL/RETURN decode (enablestak / branch path) drives push/pop.
- On CALL, the PC stage pushes the return address (PC+1). On RETURN/RETLW, the PC stage loads the address shown on `top` in the same cycle that `pop` is asserted.
- The stack is a fixed-depth circular stack with wrap-around on overflow, matching a PIC-style midrange core, plus sticky diagnostic flags.

---
 rtl/pc_return_stack_if.sv | 24 ++
 rtl/pc_return_stack.sv | 51 +++++
 tb/tb_pc_return_stack.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pc_return_stack_if.sv
// pc_return_stack_if: push/pop control and top-of-stack status between the PC stage and the return stack.
interface pc_return_stack_if #(
    parameter int AW = 13,
    parameter int PW = 3
);
    logic          push;
    logic          pop;
    logic          clear_flags;
    logic [AW-1:0] push_addr;
    logic [AW-1:0] top;
    logic [PW:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;
    modport master (
        output push, pop, clear_flags, push_addr,
        input  top, level, full, empty, overflow, underflow
    );
    modport slave (
        input  push, pop, clear_flags, push_addr,
        output top, level, full, empty, overflow, underflow
    );
endinterface

// File: rtl/pc_return_stack.sv
// pc_return_stack: circular call/return stack beside the PC, wrap-around on overflow, sticky diagnostic flags.
module pc_return_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 13,
    parameter int PW    = 3
) (
    input  logic clk,
    input  logic reset,
    pc_return_stack_if.slave bus
);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_sp;
    logic [PW:0]   r_cnt;
    logic          r_ovf;
    logic          r_unf;
    logic [PW-1:0] w_sp_m1;
    logic          w_full;
    logic          w_empty;
    logic          w_push_only;
    logic          w_pop_only;
    assign w_sp_m1     = r_sp - PW'(1);
    assign w_full      = r_cnt == FULL_CNT;
    assign w_empty     = r_cnt == '0;
    assign w_push_only = bus.push & ~bus.pop;
    assign w_pop_only  = bus.pop & ~bus.push;
    assign bus.top       = r_mem[w_sp_m1];
    assign bus.level     = r_cnt;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            // simultaneous push+pop replaces the top entry in place
            if (bus.push) r_mem[bus.pop ? w_sp_m1 : r_sp] <= bus.push_addr;
            if (w_push_only) r_sp <= r_sp + PW'(1);
            if (w_pop_only) r_sp <= w_sp_m1;
            if (w_push_only && !w_full) r_cnt <= r_cnt + 1'b1;
            if (w_pop_only && !w_empty) r_cnt <= r_cnt - 1'b1;
            r_ovf <= (r_ovf & ~bus.clear_flags) | (w_push_only & w_full);
            r_unf <= (r_unf & ~bus.clear_flags) | (w_pop_only & w_empty);
        end
    end
endmodule

// File: tb/tb_pc_return_stack.sv
// tb_pc_return_stack: directed vectors with hand-computed expectations for pc_return_stack.
module tb_pc_return_stack;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    pc_return_stack_if #(.AW(13), .PW(3)) bus ();
    pc_return_stack #(.DEPTH(8), .AW(13), .PW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic pu, input logic po, input logic [12:0] a, input logic cl);
        bus.push = pu;
        bus.pop = po;
        bus.push_addr = a;
        bus.clear_flags = cl;
        @(posedge clk);
        #2;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.clear_flags = 1'b0;
    endtask
    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask
    initial begin
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.push_addr = '0;
        bus.clear_flags = 1'b0;
        do_reset();
        cyc(0, 0, 13'h0, 0);
        chk("rst_top", 32'(bus.top), 32'h0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_unf", 32'(bus.underflow), 32'd0);
        cyc(1, 0, 13'h0005, 0);
        cyc(1, 0, 13'h0010, 0);
        cyc(1, 0, 13'h1FFF, 0);
        chk("p3_level", 32'(bus.level), 32'd3);
        chk("p3_top", 32'(bus.top), 32'h1FFF);
        cyc(0, 1, 13'h0, 0);
        chk("pop1_top", 32'(bus.top), 32'h0010);
        chk("pop1_level", 32'(bus.level), 32'd2);
        cyc(0, 1, 13'h0, 0);
        chk("pop2_top", 32'(bus.top), 32'h0005);
        chk("pop2_level", 32'(bus.level), 32'd1);
        chk("pop2_empty", 32'(bus.empty), 32'd0);
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 0, 13'(i), 0);
            if (i == 8) begin
                chk("p8_full", 32'(bus.full), 32'd1);
                chk("p8_ovf", 32'(bus.overflow), 32'd0);
            end
        end
        chk("p9_level", 32'(bus.level), 32'd8);
        chk("p9_full", 32'(bus.full), 32'd1);
        chk("p9_ovf", 32'(bus.overflow), 32'd1);
        chk("p9_top", 32'(bus.top), 32'h0009);
        for (int i = 0; i < 7; i++) cyc(0, 1, 13'h0, 0);
        chk("pop7_top", 32'(bus.top), 32'h0002);
        chk("pop7_level", 32'(bus.level), 32'd1);
        cyc(0, 1, 13'h0, 0);
        chk("pop8_top", 32'(bus.top), 32'h0009);
        chk("pop8_level", 32'(bus.level), 32'd0);
        chk("pop8_unf", 32'(bus.underflow), 32'd0);
        cyc(0, 1, 13'h0, 0);
        chk("pop9_unf", 32'(bus.underflow), 32'd1);
        chk("pop9_level", 32'(bus.level), 32'd0);
        chk("pop9_top", 32'(bus.top), 32'h0008);
        do_reset();
        cyc(1, 0, 13'h0100, 0);
        cyc(1, 1, 13'h0200, 0);
        chk("pp_level", 32'(bus.level), 32'd1);
        chk("pp_top", 32'(bus.top), 32'h0200);
        chk("pp_ovf", 32'(bus.overflow), 32'd0);
        chk("pp_unf", 32'(bus.underflow), 32'd0);
        cyc(0, 1, 13'h0, 0);
        cyc(1, 1, 13'h0333, 0);
        chk("ppe_level", 32'(bus.level), 32'd0);
        chk("ppe_unf", 32'(bus.underflow), 32'd0);
        chk("ppe_top", 32'(bus.top), 32'h0333);
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 0, 13'(i + 16), 0);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        cyc(1, 0, 13'h0777, 1);
        chk("ovf_setwins", 32'(bus.overflow), 32'd1);
        chk("ovf_top", 32'(bus.top), 32'h0777);
        cyc(0, 0, 13'h0, 1);
        chk("ovf_clear", 32'(bus.overflow), 32'd0);
        chk("ovf_lvl", 32'(bus.level), 32'd8);
        do_reset();
        cyc(1, 0, 13'h0ABC, 0);
        cyc(1, 0, 13'h0DEF, 0);
        chk("ar_pre_top", 32'(bus.top), 32'h0DEF);
        bus.push = 1'b1;
        bus.push_addr = 13'h0123;
        #1;
        reset = 1'b1;
        #1;
        chk("ar_top", 32'(bus.top), 32'h0);
        chk("ar_level", 32'(bus.level), 32'd0);
        chk("ar_empty", 32'(bus.empty), 32'd1);
        bus.push = 1'b0;
        #1;
        reset = 1'b0;
        cyc(0, 1, 13'h0, 0);
        chk("ar_unf", 32'(bus.underflow), 32'd1);
        chk("ar_lvl2", 32'(bus.level), 32'd0);
        chk("ar_top2", 32'(bus.top), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
